// File: rtl/operand_fetch.sv
// Register-read stage: reads both sources, bypasses same-cycle write-back, stalls on scoreboard hazards.
// Latency: one cycle from accept to registered operand bundle (out_valid).
// Backpressure: bundle holds while out_ready=0; in_ready drops on hazard, flush, reset or a held bundle.
module operand_fetch #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      in_rs1,
  input  logic [4:0]      in_rs2,
  input  logic [4:0]      in_rd,
  input  logic            in_rd_en,
  input  logic [XLEN-1:0] in_imm,
  input  logic [XLEN-1:0] in_pc,
  output logic [4:0]      raddr1,
  output logic [4:0]      raddr2,
  input  logic [XLEN-1:0] rdata1,
  input  logic [XLEN-1:0] rdata2,
  input  logic            wb_en,
  input  logic [4:0]      wb_addr,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_op1,
  output logic [XLEN-1:0] out_op2,
  output logic [XLEN-1:0] out_imm,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      out_rd
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [31:0]     pend_q, pend_d;
  logic [31:0]     wb_hit;
  logic [31:0]     busy;
  logic            hazard;
  logic            accept;
  logic            issue;
  logic [XLEN-1:0] op1_sel, op2_sel;

  // Register file read ports follow the decoded sources directly.
  assign raddr1 = in_rs1;
  assign raddr2 = in_rs2;

  // One-hot view of the register being written back this cycle (x0 never hits).
  always_comb begin
    wb_hit = '0;
    if (wb_en && wb_addr != 5'd0) wb_hit[wb_addr] = 1'b1;
  end

  // A register still pending but being written this cycle is no longer a hazard.
  assign busy      = pend_q & ~wb_hit;
  assign hazard    = busy[in_rs1] | busy[in_rs2] | (in_rd_en & busy[in_rd]);
  assign out_valid = (state_q == FULL);
  assign in_ready  = ~reset & ~flush & ~hazard & (~out_valid | out_ready);
  assign accept    = in_valid & in_ready;
  assign issue     = out_valid & out_ready;

  // x0 reads zero; a same-cycle write-back wins over the (stale) regfile read.
  assign op1_sel = (in_rs1 == 5'd0) ? '0 : (wb_hit[in_rs1] ? wb_data : rdata1);
  assign op2_sel = (in_rs2 == 5'd0) ? '0 : (wb_hit[in_rs2] ? wb_data : rdata2);

  // Bundle occupancy: flush drops the held bundle, otherwise accept refills and issue drains.
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (accept) state_d = FULL;
      FULL:    if (accept) state_d = FULL;
               else if (issue) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
    if (flush) state_d = EMPTY;
  end

  // Scoreboard update: write-back and flush clear, a new writer sets (set applied last so it wins).
  always_comb begin
    pend_d = pend_q & ~wb_hit;
    if (flush && out_valid && out_rd != 5'd0) pend_d[out_rd] = 1'b0;
    if (accept && in_rd_en && in_rd != 5'd0) pend_d[in_rd] = 1'b1;
    pend_d[0] = 1'b0;
  end

  // State and scoreboard registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= EMPTY;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
    end
  end

  // Operand bundle capture on accept; held otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_op1 <= '0;
      out_op2 <= '0;
      out_imm <= '0;
      out_pc  <= '0;
      out_rd  <= '0;
    end else if (accept) begin
      out_op1 <= op1_sel;
      out_op2 <= op2_sel;
      out_imm <= in_imm;
      out_pc  <= in_pc;
      out_rd  <= in_rd_en ? in_rd : 5'd0;
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: directed scenarios with literal expectations, then randomized traffic.
// A behavioural model (scoreboard bits, held bundle, register array) predicts outputs every cycle.
// Inputs change on the falling edge; outputs are compared shortly after it.
module tb_operand_fetch;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_rd_en, wb_en, out_ready;
  logic [4:0]  in_rs1, in_rs2, in_rd, wb_addr;
  logic [31:0] in_imm, in_pc, wb_data;
  logic        in_ready, out_valid;
  logic [4:0]  raddr1, raddr2, out_rd;
  logic [31:0] rdata1, rdata2, out_op1, out_op2, out_imm, out_pc;

  logic [31:0] rf [32];
  assign rdata1 = rf[raddr1];
  assign rdata2 = rf[raddr2];

  always #5 clk = ~clk;

  operand_fetch #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_rd_en(in_rd_en),
    .in_imm(in_imm), .in_pc(in_pc),
    .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1), .rdata2(rdata2),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_op1(out_op1), .out_op2(out_op2), .out_imm(out_imm), .out_pc(out_pc),
    .out_rd(out_rd)
  );

  int n_vec = 0;
  int n_err = 0;

  // Model state: which registers have an in-flight writer, and the bundle held toward execute.
  bit          m_pend [32];
  bit          m_valid;
  logic [31:0] m_op1, m_op2, m_imm, m_pc;
  logic [4:0]  m_rd;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit wb_hits(input logic [4:0] r);
    return wb_en && wb_addr == r && r != 5'd0;
  endfunction

  function automatic bit busy(input logic [4:0] r);
    return m_pend[r] && !wb_hits(r);
  endfunction

  function automatic bit model_ready();
    bit haz;
    haz = busy(in_rs1) || busy(in_rs2) || (in_rd_en && busy(in_rd));
    return !reset && !flush && !haz && (!m_valid || out_ready);
  endfunction

  function automatic logic [31:0] operand(input logic [4:0] r);
    if (r == 5'd0) return 32'd0;
    if (wb_hits(r)) return wb_data;
    return rf[r];
  endfunction

  task automatic model_clear();
    foreach (m_pend[i]) m_pend[i] = 1'b0;
    m_valid = 1'b0;
  endtask

  // Compare every meaningful output against the model, advance the model, cross one clock.
  task automatic cycle();
    bit acc;
    #1;
    if (reset) model_clear();
    check("raddr1", raddr1, in_rs1);
    check("raddr2", raddr2, in_rs2);
    check("in_ready", in_ready, model_ready());
    check("out_valid", out_valid, m_valid);
    if (m_valid) begin
      check("out_op1", out_op1, m_op1);
      check("out_op2", out_op2, m_op2);
      check("out_imm", out_imm, m_imm);
      check("out_pc", out_pc, m_pc);
      check("out_rd", out_rd, m_rd);
    end
    if (!reset) begin
      acc = in_valid && model_ready();
      if (wb_en && wb_addr != 5'd0) m_pend[wb_addr] = 1'b0;
      if (flush && m_valid && m_rd != 5'd0) m_pend[m_rd] = 1'b0;
      if (acc && in_rd_en && in_rd != 5'd0) m_pend[in_rd] = 1'b1;
      if (flush) m_valid = 1'b0;
      else if (acc) begin
        m_valid = 1'b1;
        m_op1 = operand(in_rs1);
        m_op2 = operand(in_rs2);
        m_imm = in_imm;
        m_pc  = in_pc;
        m_rd  = in_rd_en ? in_rd : 5'd0;
      end else if (m_valid && out_ready) m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    if (wb_en && wb_addr != 5'd0) rf[wb_addr] = wb_data;
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic rd_en,
                       input logic [31:0] imm, input logic [31:0] pc);
    in_valid = v; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd; in_rd_en = rd_en;
    in_imm = imm; in_pc = pc;
  endtask

  task automatic wb(input logic en, input logic [4:0] addr, input logic [31:0] data);
    wb_en = en; wb_addr = addr; wb_data = data;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    wb(0, 0, 0);
    foreach (rf[i]) rf[i] = $urandom;
    rf[0] = 32'hdead_beef;
    rf[5] = 32'd1000;
    model_clear();
    m_op1 = '0; m_op2 = '0; m_imm = '0; m_pc = '0; m_rd = '0;

    // Reset held two cycles.
    @(negedge clk);
    cycle();
    cycle();
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_op1", out_op1, 0);
    check("rst_out_rd", out_rd, 0);
    check("rst_in_ready", in_ready, 0);
    reset = 1'b0;
    #1;
    check("post_rst_in_ready", in_ready, 1);
    cycle();

    // Plain issue.
    drive(1, 5, 0, 6, 1, 7, 20);
    cycle();
    drive(0, 0, 0, 0, 0, 0, 0);
    #1;
    check("plain_valid", out_valid, 1);
    check("plain_op1", out_op1, 1000);
    check("plain_op2", out_op2, 0);
    check("plain_imm", out_imm, 7);
    check("plain_pc", out_pc, 20);
    check("plain_rd", out_rd, 6);

    // RAW stall, then accept in the write-back cycle with bypass.
    out_ready = 1'b1;
    drive(1, 6, 0, 7, 1, 3, 24);
    #1;
    check("raw_stall", in_ready, 0);
    cycle();
    wb(1, 6, 50);
    #1;
    check("raw_wb_ready", in_ready, 1);
    cycle();
    wb(0, 0, 0);
    drive(1, 6, 0, 0, 0, 11, 28);
    #1;
    check("bypass_op1", out_op1, 50);
    check("pend6_cleared", in_ready, 1);
    cycle();

    // Backpressure for three cycles, then issue and accept together.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 0, 0, 99, 32);
      #1;
      check("bp_in_ready", in_ready, 0);
      check("bp_imm_hold", out_imm, 11);
      cycle();
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", in_ready, 1);
    cycle();
    #1;
    check("bp_new_imm", out_imm, 99);

    // Set/clear collision on x31.
    drive(1, 0, 0, 31, 1, 1, 36);
    cycle();
    wb(1, 31, 77);
    drive(1, 0, 0, 31, 1, 2, 40);
    #1;
    check("collide_ready", in_ready, 1);
    cycle();
    wb(0, 0, 0);
    drive(1, 31, 0, 0, 0, 3, 44);
    #1;
    check("collide_pend31", in_ready, 0);
    cycle();
    wb(1, 31, 88);
    cycle();
    wb(0, 0, 0);

    // Flush of a held bundle writing x9.
    drive(1, 0, 0, 9, 1, 5, 48);
    cycle();
    out_ready = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    #1;
    check("flush_pre_rd", out_rd, 9);
    flush = 1'b1;
    drive(1, 0, 0, 0, 0, 6, 52);
    #1;
    check("flush_in_ready", in_ready, 0);
    cycle();
    flush = 1'b0;
    out_ready = 1'b1;
    drive(1, 9, 0, 0, 0, 7, 56);
    #1;
    check("flush_out_valid", out_valid, 0);
    check("flush_pend9", in_ready, 1);
    cycle();

    // x0 source reads zero even with a write-back to x0.
    drive(1, 0, 0, 0, 0, 8, 60);
    wb(1, 0, 123);
    cycle();
    wb(0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    #1;
    check("x0_op1", out_op1, 0);
    check("x0_op2", out_op2, 0);
    check("x0_imm", out_imm, 8);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      bit          found;
      logic [4:0]  pick;
      int          start;
      reset     = ($urandom_range(0, 299) == 0);
      flush     = ($urandom_range(0, 39) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) == 0)
        drive($urandom_range(0, 1), 5'($urandom), 5'($urandom), 5'($urandom),
              $urandom_range(0, 1), $urandom, $urandom);
      else
        drive($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
              5'($urandom_range(0, 7)), $urandom_range(0, 1), $urandom, $urandom);
      found = 1'b0;
      pick  = 5'd0;
      start = $urandom_range(1, 31);
      for (int k = 0; k < 31; k++) begin
        int r;
        r = 1 + ((start - 1 + k) % 31);
        if (!found && m_pend[r]) begin
          found = 1'b1;
          pick  = 5'(r);
        end
      end
      if (found && $urandom_range(0, 9) < 6) wb(1, pick, $urandom);
      else if ($urandom_range(0, 9) == 0)     wb(1, 5'($urandom), $urandom);
      else                                    wb(0, 5'($urandom), $urandom);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
